// File: rtl/execute_muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package execute_muldiv_sequencer_pkg;

  localparam int unsigned MULDIV_ITER = 32;
  localparam int unsigned CNT_W       = 6;

  // funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  // Execute-stage control word; is_muldiv selects the sequencer result over the ALU
  typedef struct packed {
    logic is_muldiv;
  } control_type;

  // rs1 is treated as signed by everything except the fully unsigned ops
  function automatic logic op_a_signed(muldiv_op_t op);
    return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM
  function automatic logic op_b_signed(muldiv_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/execute_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide,
// sign correction on exit and single-cycle resolution of divide special cases.
module execute_muldiv_sequencer
  import execute_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned ACC_W = 2 * XLEN;

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [ACC_W-1:0] acc_q, acc_d;     // {hi,lo}: product, or {rem,quot}
  logic [XLEN-1:0]  opnd_q, opnd_d;   // multiplicand |a| or divisor |b|
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             special_q, special_d;

  muldiv_op_t       op_in;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic [XLEN:0]    sum_c;
  logic [XLEN:0]    rem_sh;
  logic             rem_ge;
  logic [XLEN-1:0]  rem_sub;
  logic [CNT_W-1:0] cnt_dec;
  logic [ACC_W-1:0] prod;
  logic [XLEN-1:0]  quot, rem;
  logic [XLEN-1:0]  sel_res;
  logic             in_sa, in_sb;
  logic             is_min_a, is_neg1_b;

  assign op_in = muldiv_op_t'(op);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      special_q <= special_d;
    end
  end

  // Next-state and iteration datapath
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    special_d = special_q;

    in_sa     = op_a_signed(op_in) & operand_a[XLEN-1];
    in_sb     = op_b_signed(op_in) & operand_b[XLEN-1];
    abs_a     = in_sa ? XLEN'(~operand_a + XLEN'(1)) : operand_a;
    abs_b     = in_sb ? XLEN'(~operand_b + XLEN'(1)) : operand_b;
    is_min_a  = (operand_a == {1'b1, {(XLEN-1){1'b0}}});
    is_neg1_b = (operand_b == {XLEN{1'b1}});

    sum_c   = {1'b0, acc_q[ACC_W-1:XLEN]} + {1'b0, opnd_q};
    rem_sh  = acc_q[ACC_W-1:XLEN-1];
    rem_ge  = (rem_sh >= {1'b0, opnd_q});
    rem_sub = XLEN'(rem_sh - {1'b0, opnd_q});
    cnt_dec = cnt_q - CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d      = op_in;
          sign_a_d  = in_sa;
          sign_b_d  = in_sb;
          cnt_d     = CNT_W'(MULDIV_ITER);
          special_d = 1'b0;
          if (op_in[2] && (operand_b == '0)) begin
            // divide by zero: all ones for quotient, dividend for remainder
            special_d = 1'b1;
            acc_d     = {{XLEN{1'b0}}, (op_in[1] ? operand_a : {XLEN{1'b1}})};
            state_d   = S_DONE;
          end else if (op_in[2] && !op_in[0] && is_min_a && is_neg1_b) begin
            // signed overflow: quotient is the dividend, remainder is zero
            special_d = 1'b1;
            acc_d     = {{XLEN{1'b0}}, (op_in[1] ? {XLEN{1'b0}} : operand_a)};
            state_d   = S_DONE;
          end else if (op_in[2]) begin
            acc_d   = {{XLEN{1'b0}}, abs_a};
            opnd_d  = abs_b;
            state_d = S_DIV;
          end else begin
            acc_d   = {{XLEN{1'b0}}, abs_b};
            opnd_d  = abs_a;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_q[0] ? {sum_c, acc_q[XLEN-1:1]} : {1'b0, acc_q[ACC_W-1:1]};
        cnt_d = cnt_dec;
        if (cnt_dec == '0) state_d = S_DONE;
      end
      S_DIV: begin
        acc_d = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                       : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        cnt_d = cnt_dec;
        if (cnt_dec == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Sign correction and result selection from registered state
  always_comb begin
    prod    = (sign_a_q ^ sign_b_q) ? (~acc_q + ACC_W'(1)) : acc_q;
    quot    = (sign_a_q ^ sign_b_q) ? XLEN'(~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem     = sign_a_q ? XLEN'(~acc_q[ACC_W-1:XLEN] + XLEN'(1)) : acc_q[ACC_W-1:XLEN];
    sel_res = '0;
    if (special_q) begin
      sel_res = acc_q[XLEN-1:0];
    end else begin
      case (op_q)
        OP_MUL:                      sel_res = prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: sel_res = prod[ACC_W-1:XLEN];
        OP_DIV, OP_DIVU:             sel_res = quot;
        OP_REM, OP_REMU:             sel_res = rem;
        default:                     sel_res = '0;
      endcase
    end
    done   = (state_q == S_DONE);
    result = done ? sel_res : '0;
    stall  = ((state_q == S_IDLE) && start && !flush) || (state_q == S_MUL) || (state_q == S_DIV);
  end

endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
// Directed scoreboard bench for the multiply/divide sequencer.
module tb_execute_muldiv_sequencer;
  import execute_muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  execute_muldiv_sequencer #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (a),
    .operand_b (b),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .result    (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop expected result on every done pulse; result must be 0 otherwise
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL unexpected_done: got result %h with no expected entry", result);
        end else begin
          check("result", result, exp_q.pop_front());
        end
      end else begin
        check("result_when_idle", result, 32'h0);
      end
    end
  end

  // Issue one op, hold start until done, check latency and stall count
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int cyc;
    int nst;
    bit got;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    exp_q.push_back(exp);
    cyc = 0;
    nst = 0;
    got = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (stall === 1'b1) nst++;
      cyc++;
    end
    if (!got) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s_timeout: got no done within %0d cycles, required %0d", name, cyc, exp_lat);
    end else begin
      check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({name, "_stall_cycles"}, 32'(nst), 32'(exp_lat));
      check({name, "_stall_at_done"}, {31'h0, stall}, 32'h0);
    end
  endtask

  initial begin
    bit seen_done;
    rst   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall",  {31'h0, stall}, 32'h0);
    check("reset_done",   {31'h0, done},  32'h0);
    check("reset_result", result,         32'h0);
    rst = 1'b1;

    // Iterating multiply ops
    run_op("mul",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);

    // Iterating divide ops
    run_op("div",  OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem",  OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu", OP_DIVU, 32'd100,      32'd7, 32'd14,       33);
    run_op("remu", OP_REMU, 32'd100,      32'd7, 32'd2,        33);

    // Special cases resolved without iterating
    run_op("divu_by0", OP_DIVU, 32'd55,       32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_by0", OP_REMU, 32'd55,       32'd0,        32'd55,       1);
    run_op("rem_ovf",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // Flush at cycle 10 of a DIV
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd1000;
    b     = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("flush_cycle_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("after_flush_stall", {31'h0, stall}, 32'h0);
    check("after_flush_done",  {31'h0, done},  32'h0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || stall === 1'b1) seen_done = 1'b1;
    end
    check("flush_no_done_no_stall", {31'h0, seen_done}, 32'h0);

    // Reset at cycle 5 of a MUL
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = OP_MUL;
    a     = 32'd7;
    b     = 32'hFFFFFFFD;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_stall",  {31'h0, stall}, 32'h0);
    check("midrst_done",   {31'h0, done},  32'h0);
    check("midrst_result", result,         32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_op("mul_after_rst", OP_MUL, 32'd5, 32'd6, 32'd30, 33);

    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
